mxu_sequencer: RTL and testbench
================================

// Module: mxu_sequencer
// PURPOSE
//  Command-driven controller that sequences one mxu_core (M x K systolic MAC array) per job.
//  Accepts a job (base address, vector count, precision), clears the array accumulators and
//  streams input vectors from the input buffer. It tracks each vector through the array
//  pipeline and flags the array output y valid, with result backpressure. Sits between the
//  DTPU control unit and mxu_core/input buffer.
// PARAMETERS
//  M         3   array rows (matches mxu_core M)
//  K         3   array columns (matches mxu_core K)
//  ADDR_W    8   input-buffer address width; vector count width
//  PIPE_LAT  8   mxu_enable cycles from a vector on input_data to its result on y
// PORTS
//  clk                 in   1         single clock, rising edge
//  reset               in   1         asynchronous, active-low
//  cmd_valid           in   1         job request
//  cmd_ready           out  1         job accepted when cmd_valid & cmd_ready
//  cmd_base            in   ADDR_W    first input-buffer address
//  cmd_len             in   ADDR_W    number of input vectors (0 allowed)
//  cmd_dtype           in   `LOG_ALLOWED_PRECISIONS  precision select
//  cmd_fp              in   2         floating-point unit enable
//  cmd_chain           in   1         DSP cascade chain enable
//  cmd_abort           in   1         synchronous job abort
//  rd_en               out  1         input-buffer read strobe (1-cycle read latency, output held)
//  rd_addr             out  ADDR_W    input-buffer read address
//  mxu_reset           out  1         mxu_core reset, active-low
//  mxu_enable          out  1         mxu_core enable
//  mxu_enable_chain    out  1         mxu_core enable_chain
//  mxu_data_type       out  `LOG_ALLOWED_PRECISIONS  mxu_core data_type
//  mxu_enable_fp_unit  out  2         mxu_core enable_fp_unit
//  mxu_test_mode       out  1         tied 0
//  res_valid           out  1         y carries a result
//  res_ready           in   1         result consumer ready
//  busy                out  1         state != IDLE
//  done                out  1         1-cycle pulse when the job completes normally
// BEHAVIOUR
//  - Reset: state=IDLE. While reset is low: mxu_reset=0. All other outputs are 0 except
//    cmd_ready=1. Counters, tag pipe and config registers are 0. Reset takes effect
//    immediately with no clock edge.
//  - FSM:
//    - IDLE: cmd_ready=1. On accept, register cmd_* and go to LOAD.
//    - LOAD (1 cycle): mxu_reset=0 clears accumulators. Go to DONE if len=0, else STREAM.
//    - STREAM: issue reads. Go to DRAIN after the issue with issued==len-1.
//    - DRAIN: go to DONE when retired==len.
//    - DONE (1 cycle): done=1, then IDLE.
//  - Config outputs (data_type/fp/chain) come only from registers and are stable from LOAD to IDLE.
//  - stall = res_valid & ~res_ready.
//  - mxu_enable = (STREAM|DRAIN) & ~stall. rd_en = STREAM & ~stall.
//  - rd_addr = cmd_base + issued, mod 2^ADDR_W; wraps, no error.
//  - Tag pipe, PIPE_LAT+1 deep (+1 covers buffer latency):
//    - Shifts only when mxu_enable=1 and inserts rd_en.
//    - res_valid = last stage; held through stall.
//    - retired increments on res_valid & res_ready.
//  - A full stall freezes the array, buffer and tags. No result is dropped or duplicated.
//  - cmd_abort in LOAD/STREAM/DRAIN:
//    - Next state IDLE.
//    - mxu_reset=0 for that cycle, tags flushed, done not asserted.
//    - Abort wins over a simultaneous last retire.
//    - Ignored in IDLE and DONE.
//  - cmd_valid outside IDLE is ignored (cmd_ready=0).
// STRUCTURE
//  - Shared package/header (precision_def.vh): `LOG_ALLOWED_PRECISIONS, FSM state encoding
//    localparams, PIPE_LAT default.
//  - Sub-module mxu_valid_pipe: enable-gated 1-bit shift register with synchronous flush,
//    depth PIPE_LAT+1.
//  - Sequencer top: FSM, issue/retire counters, output decode.
// TESTING
//  - len=4, base=0x10, res_ready=1 -> rd_addr 0x10..0x13 on 4 consecutive cycles;
//    res_valid on 4 consecutive cycles starting PIPE_LAT+1 after the first rd_en;
//    done 1 cycle later; busy low next.
//  - len=3, res_ready held low 5 cycles at the first res_valid -> mxu_enable=rd_en=0
//    for 5 cycles, res_valid held; exactly 3 handshakes; done after the 3rd.
//  - base=0xFE, len=4 -> rd_addr FE,FF,00,01.
//  - len=0 -> accept, LOAD (mxu_reset=0 one cycle), done on the next cycle; no rd_en or mxu_enable.
//  - cmd_abort after 2 reads in STREAM -> mxu_reset=0 one cycle, IDLE next, no done,
//    no res_valid afterwards, cmd_ready=1.
//  - reset low mid-DRAIN between clock edges -> all outputs at reset values immediately;
//    after release a new job runs correctly.

Source files
------------

// File: rtl/mxu_sequencer_pkg.sv
// Shared types and constants for the mxu_sequencer job controller and its tag pipe.
package mxu_sequencer_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 2;
    localparam int PIPE_LAT_DEFAULT       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/mxu_valid_pipe.sv
// Enable-gated 1-bit shift register with synchronous flush; marks which array
// pipeline slots hold a real input vector.
module mxu_valid_pipe #(
    parameter int DEPTH = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] tags_q;
    logic [DEPTH-1:0] tags_d;

    always_comb begin
        tags_d = tags_q;
        if (flush) begin
            tags_d = '0;
        end else if (enable) begin
            tags_d = {tags_q[DEPTH-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign dout = tags_q[DEPTH-1];

endmodule

// File: rtl/mxu_sequencer.sv
// Job controller for one mxu_core: clears the accumulators, streams input vectors
// from the input buffer and flags each result on y, honouring result backpressure.
module mxu_sequencer
    import mxu_sequencer_pkg::*;
#(
    parameter int M        = 3,
    parameter int K        = 3,
    parameter int ADDR_W   = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [ADDR_W-1:0]                 cmd_base,
    input  logic [ADDR_W-1:0]                 cmd_len,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] cmd_dtype,
    input  logic [1:0]                        cmd_fp,
    input  logic                              cmd_chain,
    input  logic                              cmd_abort,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic                              mxu_reset,
    output logic                              mxu_enable,
    output logic                              mxu_enable_chain,
    output logic [LOG_ALLOWED_PRECISIONS-1:0] mxu_data_type,
    output logic [1:0]                        mxu_enable_fp_unit,
    output logic                              mxu_test_mode,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              busy,
    output logic                              done
);

    if (M < 1 || K < 1 || PIPE_LAT < 1) begin : g_bad_params
        $error("mxu_sequencer: M, K and PIPE_LAT must be at least 1");
    end

    state_e                            state_q, state_d;
    logic [ADDR_W-1:0]                 base_q, base_d;
    logic [ADDR_W-1:0]                 len_q, len_d;
    logic [ADDR_W-1:0]                 issued_q, issued_d;
    logic [ADDR_W-1:0]                 retired_q, retired_d;
    logic [LOG_ALLOWED_PRECISIONS-1:0] dtype_q, dtype_d;
    logic [1:0]                        fp_q, fp_d;
    logic                              chain_q, chain_d;
    logic                              stall, retire, abort, in_job;

    always_comb begin
        stall      = res_valid & ~res_ready;
        retire     = res_valid & res_ready;
        in_job     = (state_q == ST_LOAD) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
        abort      = in_job & cmd_abort;
        rd_en      = (state_q == ST_STREAM) & ~stall;
        mxu_enable = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) & ~stall;
        // Accumulators are cleared while reset is held, during LOAD and on an abort.
        mxu_reset  = reset & (state_q != ST_LOAD) & ~abort;
        cmd_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        rd_addr    = base_q + issued_q;

        mxu_data_type      = dtype_q;
        mxu_enable_fp_unit = fp_q;
        mxu_enable_chain   = chain_q;
        mxu_test_mode      = 1'b0;

        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        dtype_d   = dtype_q;
        fp_d      = fp_q;
        chain_d   = chain_q;
        issued_d  = issued_q + ADDR_W'(rd_en);
        retired_d = retired_q + ADDR_W'(retire);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_LOAD;
                    base_d    = cmd_base;
                    len_d     = cmd_len;
                    dtype_d   = cmd_dtype;
                    fp_d      = cmd_fp;
                    chain_d   = cmd_chain;
                    issued_d  = '0;
                    retired_d = '0;
                end
            end
            ST_LOAD:   state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: if (rd_en && issued_q == len_q - ADDR_W'(1)) state_d = ST_DRAIN;
            // Compare against the post-retire count so done follows the last handshake directly.
            ST_DRAIN:  if (retired_d == len_q) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            dtype_q   <= '0;
            fp_q      <= '0;
            chain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            dtype_q   <= dtype_d;
            fp_q      <= fp_d;
            chain_q   <= chain_d;
        end
    end

    // One extra stage covers the input buffer's read latency ahead of the array.
    mxu_valid_pipe #(
        .DEPTH(PIPE_LAT + 1)
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .enable(mxu_enable),
        .flush (abort),
        .din   (rd_en),
        .dout  (res_valid)
    );

endmodule

// File: tb/tb_mxu_sequencer.sv
// Bench for mxu_sequencer: job table, hand-written stall/abort/reset sequences and
// randomized jobs checked every cycle against a transaction-level reference model.
module tb_mxu_sequencer;
    import mxu_sequencer_pkg::*;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_chain, cmd_abort;
    logic [7:0] cmd_base, cmd_len;
    logic [1:0] cmd_dtype, cmd_fp;
    logic       rd_en, mxu_reset, mxu_enable, mxu_enable_chain, mxu_test_mode;
    logic [7:0] rd_addr;
    logic [1:0] mxu_data_type, mxu_enable_fp_unit;
    logic       res_valid, res_ready, busy, done;

    mxu_sequencer #(.M(3), .K(3), .ADDR_W(8), .PIPE_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_dtype(cmd_dtype), .cmd_fp(cmd_fp),
        .cmd_chain(cmd_chain), .cmd_abort(cmd_abort), .rd_en(rd_en), .rd_addr(rd_addr),
        .mxu_reset(mxu_reset), .mxu_enable(mxu_enable), .mxu_enable_chain(mxu_enable_chain),
        .mxu_data_type(mxu_data_type), .mxu_enable_fp_unit(mxu_enable_fp_unit),
        .mxu_test_mode(mxu_test_mode), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: job phase plus the list of in-flight reads, each tagged
    // with how many array-enable cycles it has seen so far.
    int   ph;            // 0 idle, 1 clearing, 2 running, 3 finishing
    int   m_base, m_len, m_issued, m_retired;
    logic [1:0] m_dtype, m_fp;
    logic m_chain;
    int   ages[$];
    logic model_on = 1'b0;
    logic m_rv, m_stall, m_en, m_rd, m_abort;

    task automatic model_init();
        ph = 0; m_base = 0; m_len = 0; m_issued = 0; m_retired = 0;
        m_dtype = '0; m_fp = '0; m_chain = 1'b0;
        ages.delete();
    endtask

    task automatic check_model();
        m_rv    = (ages.size() > 0) && (ages[0] == LAT + 1);
        m_stall = m_rv && !res_ready;
        m_en    = (ph == 2) && !m_stall;
        m_rd    = m_en && (m_issued < m_len);
        m_abort = cmd_abort && (ph == 1 || ph == 2);
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 3);
        chk("mxu_reset", mxu_reset, !(ph == 1 || m_abort));
        chk("mxu_enable", mxu_enable, m_en);
        chk("rd_en", rd_en, m_rd);
        chk("res_valid", res_valid, m_rv);
        chk("test_mode", mxu_test_mode, 0);
        chk("data_type", mxu_data_type, m_dtype);
        chk("fp_unit", mxu_enable_fp_unit, m_fp);
        chk("chain", mxu_enable_chain, m_chain);
        if (m_rd) chk("rd_addr", rd_addr, (m_base + m_issued) % 256);
    endtask

    task automatic model_advance();
        if (m_abort) begin
            ages.delete();
            ph = 0;
        end else begin
            if (m_rv && res_ready) begin
                void'(ages.pop_front());
                m_retired++;
            end
            if (m_en) begin
                foreach (ages[i]) ages[i]++;
                if (m_rd) begin
                    ages.push_back(1);
                    m_issued++;
                end
            end
            case (ph)
                0: if (cmd_valid) begin
                    ph = 1; m_base = cmd_base; m_len = cmd_len; m_dtype = cmd_dtype;
                    m_fp = cmd_fp; m_chain = cmd_chain; m_issued = 0; m_retired = 0;
                end
                1: ph = (m_len == 0) ? 3 : 2;
                2: if (m_retired == m_len) ph = 3;
                default: ph = 0;
            endcase
        end
    endtask

    logic o_rd, o_en, o_rv, o_done, o_busy, o_cready, o_mrst;
    logic [7:0] o_addr;

    // One clock cycle with the currently driven inputs; outputs sampled at negedge.
    task automatic tick();
        @(negedge clk);
        if (model_on) check_model();
        o_rd = rd_en; o_en = mxu_enable; o_rv = res_valid; o_done = done;
        o_busy = busy; o_cready = cmd_ready; o_mrst = mxu_reset; o_addr = rd_addr;
        @(posedge clk);
        if (model_on) model_advance();
        #1;
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        logic [1:0] dtype;
        logic [1:0] fp;
        logic       chain;
        int         exp_first_rv;
        int         exp_done;
        logic [7:0] exp_last_addr;
    } vec_t;

    vec_t tbl[5];

    task automatic start_job(input logic [7:0] b, input logic [7:0] l,
                             input logic [1:0] dt, input logic [1:0] fp, input logic ch);
        cmd_valid = 1'b1; cmd_base = b; cmd_len = l; cmd_dtype = dt; cmd_fp = fp; cmd_chain = ch;
    endtask

    task automatic run_table_job(input vec_t v);
        int first_rv = -1, last_rv = -1, done_at = -1, n_rv = 0, n_rd = 0, n_en = 0, n_mrst = 0;
        logic [7:0] last_addr = '0;
        start_job(v.base, v.len, v.dtype, v.fp, v.chain);
        res_ready = 1'b1;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            tick();
            if (c == 0) cmd_valid = 1'b0;
            if (o_rd) begin
                chk("tbl_addr", o_addr, 8'(v.base + 8'(n_rd)));
                last_addr = o_addr;
                n_rd++;
            end
            if (o_en) n_en++;
            if (!o_mrst) n_mrst++;
            if (o_rv) begin
                if (first_rv < 0) first_rv = c;
                last_rv = c;
                n_rv++;
            end
            if (o_done) done_at = c;
        end
        chk("tbl_first_rv", first_rv, v.exp_first_rv);
        chk("tbl_done_cycle", done_at, v.exp_done);
        chk("tbl_results", n_rv, v.len);
        chk("tbl_reads", n_rd, v.len);
        chk("tbl_enables", n_en, v.exp_done - 2);
        chk("tbl_clear_cycles", n_mrst, 1);
        if (n_rv > 0) chk("tbl_rv_contig", last_rv - first_rv + 1, n_rv);
        if (v.len != 0) chk("tbl_last_addr", last_addr, v.exp_last_addr);
        tick();
        chk("tbl_idle_after", {o_busy, o_cready}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalled, hs, done_at, n_rd_pre, rv_after, done_seen, guard;

        tbl[0] = '{8'h10, 8'd4,  2'd1, 2'd0, 1'b1, 11, 15, 8'h13};
        tbl[1] = '{8'hFE, 8'd4,  2'd2, 2'd3, 1'b0, 11, 15, 8'h01};
        tbl[2] = '{8'h00, 8'd0,  2'd3, 2'd1, 1'b1, -1,  2, 8'h00};
        tbl[3] = '{8'h7F, 8'd1,  2'd0, 2'd2, 1'b0, 11, 12, 8'h7F};
        tbl[4] = '{8'hF8, 8'd12, 2'd1, 2'd1, 1'b1, 11, 23, 8'h03};

        reset = 1'b0; cmd_valid = 0; cmd_base = 0; cmd_len = 0; cmd_dtype = 0;
        cmd_fp = 0; cmd_chain = 0; cmd_abort = 0; res_ready = 1'b1;
        model_init();
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mxu_reset", mxu_reset, 0);
        chk("rst_outputs", {rd_en, rd_addr, mxu_enable, mxu_enable_chain, mxu_data_type,
                            mxu_enable_fp_unit, mxu_test_mode, res_valid, busy, done}, 0);
        reset = 1'b1;
        model_on = 1'b1;
        tick();

        foreach (tbl[i]) run_table_job(tbl[i]);

        // Backpressure: consumer holds off for 5 cycles at the first result.
        start_job(8'h20, 8'd3, 2'd1, 2'd1, 1'b0);
        stalled = 0; hs = 0; done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            res_ready = !(c >= 11 && c <= 15);
            tick();
            if (c == 0) cmd_valid = 1'b0;
            if (c >= 11 && c <= 15 && !o_en && !o_rd && o_rv) stalled++;
            if (o_rv && res_ready) hs++;
            if (o_done) done_at = c;
        end
        chk("stall_cycles", stalled, 5);
        chk("stall_handshakes", hs, 3);
        chk("stall_done_cycle", done_at, 19);
        res_ready = 1'b1;
        tick();

        // Abort after two reads.
        start_job(8'h40, 8'd6, 2'd2, 2'd0, 1'b1);
        n_rd_pre = 0; rv_after = 0; done_seen = 0;
        for (int c = 0; c < 26; c++) begin
            cmd_abort = (c == 4);
            tick();
            if (c == 0) cmd_valid = 1'b0;
            if (c < 4 && o_rd) n_rd_pre++;
            if (c == 4) chk("abort_mxu_reset", o_mrst, 0);
            if (c == 5) chk("abort_idle", {o_busy, o_cready}, 2'b01);
            if (c >= 5 && o_rv) rv_after++;
            if (c >= 4 && o_done) done_seen++;
        end
        cmd_abort = 1'b0;
        chk("abort_reads_before", n_rd_pre, 2);
        chk("abort_no_results", rv_after, 0);
        chk("abort_no_done", done_seen, 0);

        // Asynchronous reset in the middle of DRAIN.
        start_job(8'h30, 8'd4, 2'd3, 2'd2, 1'b1);
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) cmd_valid = 1'b0;
        end
        model_on = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_mxu_reset", mxu_reset, 0);
        chk("arst_outputs", {rd_en, rd_addr, mxu_enable, mxu_enable_chain, mxu_data_type,
                             mxu_enable_fp_unit, mxu_test_mode, res_valid, busy, done}, 0);
        tick();
        tick();
        reset = 1'b1;
        model_init();
        model_on = 1'b1;
        tick();
        run_table_job(tbl[0]);

        // Randomized jobs with random backpressure, stray commands and aborts.
        for (int j = 0; j < 30; j++) begin
            start_job(8'($urandom), 8'($urandom_range(0, 10)), 2'($urandom),
                      2'($urandom), 1'($urandom));
            res_ready = 1'b1; cmd_abort = 1'b0;
            tick();
            guard = 0;
            while (ph != 0 && guard < 300) begin
                res_ready = ($urandom_range(0, 9) < 7);
                cmd_abort = ($urandom_range(0, 59) == 0);
                cmd_valid = ($urandom_range(0, 7) == 0);
                cmd_base  = 8'($urandom);
                cmd_len   = 8'($urandom);
                tick();
                guard++;
            end
            if (guard >= 300) chk("rand_job_timeout", guard, 0);
            cmd_valid = 1'b0; cmd_abort = 1'b0; res_ready = 1'b1;
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
